// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive path: bit-timer state encoding,
// default bit/byte timing constants and the bit-stuffing run length.
package usb_rx_pkg;

    // Bit-timer states: idle, waiting for the first edge, running bit phase
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } rx_state_t;

    // Default system clocks per USB bit and data bits per byte
    localparam int DEF_CLKS_PER_BIT  = 8;
    localparam int DEF_BITS_PER_BYTE = 8;

    // Number of consecutive data ones after which a stuff bit follows
    localparam int STUFF_RUN_LEN = 6;

endpackage

// File: rtl/rx_bit_timer.sv
// USB receive bit-timing controller. Recovers bit phase from D+ edges,
// strobes the RX shift register once per bit, drops stuff bits and
// signals each completed byte.
//
// Strobe semantics: shift_enable, stuff_skip and stuff_err are one-cycle
// pulses with no backpressure; they are valid in the cycle they are high
// and the consumer must act in that cycle. byte_received follows the
// final shift_enable of a byte by exactly one cycle.
module rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter int SAMPLE_OFFSET = 3,
    parameter int BITS_PER_BYTE = DEF_BITS_PER_BYTE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rcving,
    input  logic                             d_edge,
    input  logic                             d_decoded,
    output logic                             shift_enable,
    output logic                             stuff_skip,
    output logic                             stuff_err,
    output logic                             byte_received,
    output logic [$clog2(BITS_PER_BYTE)-1:0] bit_cnt,
    output rx_state_t                        dbg_state
);

    localparam int PH_W   = $clog2(CLKS_PER_BIT);
    localparam int BC_W   = $clog2(BITS_PER_BYTE);
    localparam int ONES_W = $clog2(STUFF_RUN_LEN + 1);

    localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(SAMPLE_OFFSET);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(BITS_PER_BYTE - 1);
    localparam logic [ONES_W-1:0] ONES_LAST = ONES_W'(STUFF_RUN_LEN - 1);

    rx_state_t         r_state;
    logic [PH_W-1:0]   r_ph;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [ONES_W-1:0] r_ones_cnt;
    logic              r_skip_pend;
    logic              r_byte_received;

    logic w_sample;
    logic w_shift;
    logic w_byte_done;

    // Sample point and per-bit strobes, decoded from registered phase state
    always_comb begin
        w_sample    = (r_state == RUN) && (r_ph == PH_SAMPLE);
        w_shift     = w_sample && !r_skip_pend;
        w_byte_done = w_shift && (r_bit_cnt == BC_LAST);
    end

    // Bit-timing FSM with phase, bit and ones counters; rcving low aborts
    // everything except a byte that completes in the abort cycle itself
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_ph            <= '0;
            r_bit_cnt       <= '0;
            r_ones_cnt      <= '0;
            r_skip_pend     <= 1'b0;
            r_byte_received <= 1'b0;
        end else begin
            r_byte_received <= w_byte_done;
            if (!rcving) begin
                r_state     <= IDLE;
                r_ph        <= '0;
                r_bit_cnt   <= '0;
                r_ones_cnt  <= '0;
                r_skip_pend <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= ARMED;
                    end
                    ARMED: begin
                        // The first edge is phase 0 of the first bit
                        if (d_edge) begin
                            r_state <= RUN;
                            r_ph    <= PH_ONE;
                        end
                    end
                    RUN: begin
                        // Any edge resyncs; a coincident sample still fires
                        if (d_edge) begin
                            r_ph <= PH_ONE;
                        end else if (r_ph == PH_LAST) begin
                            r_ph <= '0;
                        end else begin
                            r_ph <= r_ph + PH_W'(1);
                        end
                        if (w_sample) begin
                            if (r_skip_pend) begin
                                r_ones_cnt  <= '0;
                                r_skip_pend <= 1'b0;
                            end else begin
                                r_ones_cnt  <= d_decoded ? r_ones_cnt + ONES_W'(1) : '0;
                                r_skip_pend <= (r_ones_cnt == ONES_LAST) && d_decoded;
                                r_bit_cnt   <= (r_bit_cnt == BC_LAST) ? '0 : r_bit_cnt + BC_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign shift_enable  = w_shift;
    assign stuff_skip    = w_sample && r_skip_pend;
    assign stuff_err     = w_sample && r_skip_pend && d_decoded;
    assign byte_received = r_byte_received;
    assign bit_cnt       = r_bit_cnt;
    assign dbg_state     = r_state;

endmodule
